traffic_phase_arbiter: RTL and testbench



---
 rtl/traffic_pkg.sv | 57 +++++
 rtl/traffic_phase_arbiter_if.sv | 22 ++
 rtl/bcd_down_counter.sv | 52 +++++
 rtl/traffic_phase_arbiter.sv | 143 ++++++++++++++
 tb/tb_traffic_phase_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase scheduler.
//   - one-hot phase encodings, lamp patterns per phase, walk-lamp patterns
//   - grant encoding for the side/pedestrian round-robin
//   - 2-digit BCD payload type plus binary<->BCD helpers
package traffic_pkg;

  localparam int unsigned STATE_W = 8;
  localparam int unsigned LEDR_W  = 6;
  localparam int unsigned PED_W   = 2;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned REM_W   = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_MAIN_G = 8'b0000_0001,
    ST_MAIN_Y = 8'b0000_0010,
    ST_RED1   = 8'b0000_0100,
    ST_SIDE_G = 8'b0000_1000,
    ST_SIDE_Y = 8'b0001_0000,
    ST_PED_W  = 8'b0010_0000,
    ST_PED_F  = 8'b0100_0000,
    ST_RED2   = 8'b1000_0000
  } state_e;

  typedef enum logic {
    GRANT_SIDE = 1'b0,
    GRANT_PED  = 1'b1
  } grant_e;

  // {main R,G,Y, side R,G,Y}
  localparam logic [LEDR_W-1:0] LEDR_MAIN_G  = 6'b010100;
  localparam logic [LEDR_W-1:0] LEDR_MAIN_Y  = 6'b001100;
  localparam logic [LEDR_W-1:0] LEDR_SIDE_G  = 6'b100010;
  localparam logic [LEDR_W-1:0] LEDR_SIDE_Y  = 6'b100001;
  localparam logic [LEDR_W-1:0] LEDR_ALL_RED = 6'b100100;

  // {don't-walk, walk}
  localparam logic [PED_W-1:0] PED_LED_DONT = 2'b10;
  localparam logic [PED_W-1:0] PED_LED_WALK = 2'b01;
  localparam logic [PED_W-1:0] PED_LED_OFF  = 2'b00;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd2_t;

  function automatic bcd2_t to_bcd(input int unsigned v);
    bcd2_t b;
    b.tens = DIGIT_W'(v / 10);
    b.ones = DIGIT_W'(v % 10);
    return b;
  endfunction

  function automatic logic [REM_W-1:0] bcd_to_bin(input bcd2_t b);
    return REM_W'(b.tens) * REM_W'(10) + REM_W'(b.ones);
  endfunction

endpackage

// File: rtl/traffic_phase_arbiter_if.sv
// Request inputs and lamp/display outputs of the phase scheduler.
//   master: drives tick, is_car, ped_req; observes LEDR, ped_led, num1, num0
//   slave : the scheduler itself
interface traffic_phase_arbiter_if;
  logic       tick;
  logic       is_car;
  logic       ped_req;
  logic [5:0] LEDR;
  logic [1:0] ped_led;
  logic [3:0] num0;
  logic [3:0] num1;

  modport master (
    output tick, is_car, ped_req,
    input  LEDR, ped_led, num0, num1
  );

  modport slave (
    input  tick, is_car, ped_req,
    output LEDR, ped_led, num0, num1
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter that saturates at 00.
//   clk, rst     : clock, synchronous active-high reset (loads RST_VAL)
//   load_i       : load load_val_i (wins over dec_i)
//   load_val_i   : BCD value to load
//   dec_i        : decrement by one when non-zero
//   num1_o/num0_o: tens/ones digits
//   zero_o       : value is 00
module bcd_down_counter
  import traffic_pkg::*;
#(
  parameter bcd2_t RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  bcd2_t              load_val_i,
  input  logic               dec_i,
  output logic [DIGIT_W-1:0] num1_o,
  output logic [DIGIT_W-1:0] num0_o,
  output logic               zero_o
);

  bcd2_t cnt_q, cnt_d;

  // Load has priority; ones digit borrows from tens when it wraps 0 -> 9.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      if (cnt_q.ones == DIGIT_W'(0)) begin
        cnt_d.ones = DIGIT_W'(9);
        cnt_d.tens = cnt_q.tens - DIGIT_W'(1);
      end else begin
        cnt_d.ones = cnt_q.ones - DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign num1_o = cnt_q.tens;
  assign num0_o = cnt_q.ones;

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Intersection phase scheduler: main road owns the crossing by default, side
// road and pedestrians are granted round-robin through an all-red clearance.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tick/is_car/ped_req in; LEDR lamps, ped_led walk lamps and the
//              BCD countdown num1:num0 out (Moore-decoded, no output stage)
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned MAIN_MIN    = 60,
  parameter int unsigned YEL_T       = 3,
  parameter int unsigned ALLRED_T    = 1,
  parameter int unsigned SIDE_MAX    = 30,
  parameter int unsigned SIDE_MIN    = 5,
  parameter int unsigned PED_WALK_T  = 15,
  parameter int unsigned PED_FLASH_T = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  traffic_phase_arbiter_if.slave bus
);

  localparam bcd2_t MAIN_MIN_BCD = to_bcd(MAIN_MIN);
  localparam bcd2_t YEL_BCD      = to_bcd(YEL_T);
  localparam bcd2_t ALLRED_BCD   = to_bcd(ALLRED_T);
  localparam bcd2_t SIDE_MAX_BCD = to_bcd(SIDE_MAX);
  localparam bcd2_t WALK_BCD     = to_bcd(PED_WALK_T);
  localparam bcd2_t FLASH_BCD    = to_bcd(PED_FLASH_T);
  // Gap-out is allowed once SIDE_MIN ticks of side green have elapsed.
  localparam logic [REM_W-1:0] GAP_LIMIT = REM_W'(SIDE_MAX - SIDE_MIN);
  // Walk lamp is lit while the flash countdown has the same parity as its start.
  localparam logic FLASH_PARITY = 1'(PED_FLASH_T % 2);

  state_e             state_q, state_d;
  logic               ped_pend_q, ped_pend_d;
  grant_e             last_grant_q, last_grant_d;
  logic               cnt_load_c;
  bcd2_t              cnt_load_val_c;
  logic               rem_zero_c;
  logic [DIGIT_W-1:0] rem_tens, rem_ones;
  bcd2_t              rem_c;
  logic [REM_W-1:0]   rem_bin_c;
  logic               flash_on_c;

  // Phase countdown; reset and every phase entry reload it.
  bcd_down_counter #(
    .RST_VAL (MAIN_MIN_BCD)
  ) u_rem (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_load_val_c),
    .dec_i      (bus.tick),
    .num1_o     (rem_tens),
    .num0_o     (rem_ones),
    .zero_o     (rem_zero_c)
  );

  assign rem_c      = '{tens: rem_tens, ones: rem_ones};
  assign rem_bin_c  = bcd_to_bin(rem_c);
  assign flash_on_c = (rem_ones[0] == FLASH_PARITY);
  assign bus.num1   = rem_tens;
  assign bus.num0   = rem_ones;

  // State, pending pedestrian request and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_MAIN_G;
      ped_pend_q   <= 1'b0;
      last_grant_q <= GRANT_PED;
    end else begin
      state_q      <= state_d;
      ped_pend_q   <= ped_pend_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next phase, grant bookkeeping and countdown reload value.
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    ped_pend_d     = ped_pend_q;
    cnt_load_c     = 1'b0;
    cnt_load_val_c = MAIN_MIN_BCD;

    case (state_q)
      ST_MAIN_G: if (rem_zero_c && (bus.is_car || ped_pend_q)) state_d = ST_MAIN_Y;
      ST_MAIN_Y: if (rem_zero_c) state_d = ST_RED1;
      ST_RED1: begin
        if (rem_zero_c) begin
          // On a tie the requester that did not win last time is served.
          if (bus.is_car && (!ped_pend_q || last_grant_q == GRANT_PED)) begin
            state_d      = ST_SIDE_G;
            last_grant_d = GRANT_SIDE;
          end else if (ped_pend_q) begin
            state_d      = ST_PED_W;
            last_grant_d = GRANT_PED;
          end else begin
            state_d      = ST_MAIN_G;
          end
        end
      end
      ST_SIDE_G: if (rem_zero_c || (!bus.is_car && rem_bin_c <= GAP_LIMIT)) state_d = ST_SIDE_Y;
      ST_SIDE_Y: if (rem_zero_c) state_d = ST_RED2;
      ST_PED_W:  if (rem_zero_c) state_d = ST_PED_F;
      ST_PED_F:  if (rem_zero_c) state_d = ST_RED2;
      ST_RED2:   if (rem_zero_c) state_d = ST_MAIN_G;
      default:   state_d = ST_MAIN_G;
    endcase

    // Entering walk consumes the request, even one arriving on that edge.
    if (state_d == ST_PED_W && state_q != ST_PED_W) begin
      ped_pend_d = 1'b0;
    end else if (bus.ped_req) begin
      ped_pend_d = 1'b1;
    end

    cnt_load_c = (state_d != state_q);
    case (state_d)
      ST_MAIN_Y, ST_SIDE_Y: cnt_load_val_c = YEL_BCD;
      ST_RED1, ST_RED2:     cnt_load_val_c = ALLRED_BCD;
      ST_SIDE_G:            cnt_load_val_c = SIDE_MAX_BCD;
      ST_PED_W:             cnt_load_val_c = WALK_BCD;
      ST_PED_F:             cnt_load_val_c = FLASH_BCD;
      default:              cnt_load_val_c = MAIN_MIN_BCD;
    endcase
  end

  // Lamp decode from the registered phase.
  always_comb begin
    bus.LEDR    = LEDR_ALL_RED;
    bus.ped_led = PED_LED_DONT;
    case (state_q)
      ST_MAIN_G: bus.LEDR    = LEDR_MAIN_G;
      ST_MAIN_Y: bus.LEDR    = LEDR_MAIN_Y;
      ST_SIDE_G: bus.LEDR    = LEDR_SIDE_G;
      ST_SIDE_Y: bus.LEDR    = LEDR_SIDE_Y;
      ST_PED_W:  bus.ped_led = PED_LED_WALK;
      ST_PED_F:  bus.ped_led = flash_on_c ? PED_LED_WALK : PED_LED_OFF;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Self-checking bench for traffic_phase_arbiter with a phase-level reference model.
module tb_traffic_phase_arbiter;

  localparam int P_MG = 0;
  localparam int P_MY = 1;
  localparam int P_R1 = 2;
  localparam int P_SG = 3;
  localparam int P_SY = 4;
  localparam int P_PW = 5;
  localparam int P_PF = 6;
  localparam int P_R2 = 7;
  localparam int GAP  = 30 - 5;

  logic clk;
  logic rst;

  traffic_phase_arbiter_if bus ();

  traffic_phase_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: phase, remaining ticks, pending walk, last grant (0 side, 1 ped).
  int m_ph    = P_MG;
  int m_rem   = 0;
  int m_last  = 1;
  bit m_pend  = 1'b0;
  bit m_walk  = 1'b0;
  bit m_valid = 1'b0;
  int grants[$];

  function automatic int dur(input int p);
    case (p)
      P_MG:       return 60;
      P_MY, P_SY: return 3;
      P_R1, P_R2: return 1;
      P_SG:       return 30;
      P_PW:       return 15;
      default:    return 5;
    endcase
  endfunction

  function automatic logic [5:0] lamp(input int p);
    case (p)
      P_MG:    return 6'b010100;
      P_MY:    return 6'b001100;
      P_SG:    return 6'b100010;
      P_SY:    return 6'b100001;
      default: return 6'b100100;
    endcase
  endfunction

  function automatic logic [1:0] walk_lamp(input int p, input bit w);
    if (p == P_PW) return 2'b01;
    if (p == P_PF) return w ? 2'b01 : 2'b00;
    return 2'b10;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_ledr, input logic [3:0] e_n1,
                         input logic [3:0] e_n0, input logic [1:0] e_ped);
    chk({tag, ".LEDR"},    8'(bus.LEDR),    8'(e_ledr));
    chk({tag, ".num1"},    8'(bus.num1),    8'(e_n1));
    chk({tag, ".num0"},    8'(bus.num0),    8'(e_n0));
    chk({tag, ".ped_led"}, 8'(bus.ped_led), 8'(e_ped));
  endtask

  // One clock edge of the intersection, expressed as phase rules.
  task automatic model_step(input bit r, input bit t, input bit c, input bit p);
    int np;
    if (r) begin
      m_ph = P_MG; m_rem = 60; m_pend = 1'b0; m_last = 1; m_walk = 1'b0;
      grants.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      np = m_ph;
      case (m_ph)
        P_MG: if (m_rem == 0 && (c || m_pend)) np = P_MY;
        P_MY: if (m_rem == 0) np = P_R1;
        P_R1: if (m_rem == 0) begin
          if (c && m_pend) np = (m_last == 0) ? P_PW : P_SG;
          else if (c)      np = P_SG;
          else if (m_pend) np = P_PW;
          else             np = P_MG;
          if (np == P_SG) begin m_last = 0; grants.push_back(0); end
          if (np == P_PW) begin m_last = 1; grants.push_back(1); end
        end
        P_SG: if (m_rem == 0 || (!c && m_rem <= GAP)) np = P_SY;
        P_SY: if (m_rem == 0) np = P_R2;
        P_PW: if (m_rem == 0) np = P_PF;
        P_PF: if (m_rem == 0) np = P_R2;
        default: if (m_rem == 0) np = P_MG;
      endcase
      if (np == P_PW && m_ph != P_PW) m_pend = 1'b0;
      else if (p)                     m_pend = 1'b1;
      if (np != m_ph) begin
        m_rem  = dur(np);
        m_walk = (np == P_PF);
      end else begin
        if (t && m_rem > 0) m_rem--;
        if (t && m_ph == P_PF) m_walk = !m_walk;
      end
      m_ph = np;
    end
  endtask

  // Drive one cycle, advance the model on the edge, compare on the falling edge.
  task automatic step(input bit r, input bit t, input bit c, input bit p);
    rst = r; bus.tick = t; bus.is_car = c; bus.ped_req = p;
    @(posedge clk);
    model_step(r, t, c, p);
    @(negedge clk);
    if (m_valid)
      chk_out("cycle", lamp(m_ph), 4'(m_rem / 10), 4'(m_rem % 10), walk_lamp(m_ph, m_walk));
  endtask

  task automatic run_until(input int target, input bit c, input string tag);
    int n;
    n = 0;
    while (m_ph != target && n < 3000) begin
      step(1'b0, 1'b1, c, 1'b0);
      n++;
    end
    chk({"reach_", tag}, 8'(m_ph), 8'(target));
  endtask

  initial begin
    int n;
    bit car;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk_out("reset", 6'b010100, 4'd6, 4'd0, 2'b10);

    // Idle main green counts down and holds at 00
    step(0, 1, 0, 0);
    chk_out("idle_59", 6'b010100, 4'd5, 4'd9, 2'b10);
    for (int i = 0; i < 99; i++) step(0, 1, 0, 0);
    chk_out("idle_hold", 6'b010100, 4'd0, 4'd0, 2'b10);

    // Car arrives: yellow, clearance, side green
    step(0, 0, 1, 0);
    chk_out("main_y", 6'b001100, 4'd0, 4'd3, 2'b10);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    chk_out("red1", 6'b100100, 4'd0, 4'd1, 2'b10);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    chk_out("side_g", 6'b100010, 4'd3, 4'd0, 2'b10);

    // Gap-out once the side minimum has elapsed
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    chk_out("gap25", 6'b100001, 4'd0, 4'd3, 2'b10);
    run_until(P_MG, 0, "main1");
    chk_out("main_reload", 6'b010100, 4'd6, 4'd0, 2'b10);

    // Early gap request held until the minimum is met
    run_until(P_SG, 1, "side2");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    chk_out("gap27_hold", 6'b100010, 4'd2, 4'd7, 2'b10);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk_out("gap25_still", 6'b100010, 4'd2, 4'd5, 2'b10);
    step(0, 0, 0, 0);
    chk_out("gap27_exit", 6'b100001, 4'd0, 4'd3, 2'b10);

    // Pedestrian pulse in main green
    run_until(P_MG, 0, "main2");
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
    chk_out("ped_at40", 6'b010100, 4'd4, 4'd0, 2'b10);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    run_until(P_PW, 0, "walk");
    chk_out("walk", 6'b100100, 4'd1, 4'd5, 2'b01);
    run_until(P_PF, 0, "flash");
    chk_out("flash5", 6'b100100, 4'd0, 4'd5, 2'b01);
    step(0, 1, 0, 0);
    chk_out("flash4", 6'b100100, 4'd0, 4'd4, 2'b00);
    step(0, 1, 0, 0);
    chk_out("flash3", 6'b100100, 4'd0, 4'd3, 2'b01);
    run_until(P_MG, 0, "main3");
    for (int i = 0; i < 70; i++) step(0, 1, 0, 0);
    chk_out("ped_cleared", 6'b010100, 4'd0, 4'd0, 2'b10);

    // Round-robin with both requesters always present
    step(1, 0, 0, 0);
    n = 0;
    while (grants.size() < 4 && n < 4000) begin
      step(0, 1, 1, (n % 7) == 0);
      n++;
    end
    chk("grant_count", 8'(grants.size()), 8'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk($sformatf("grant_%0d", i), 8'(grants[i]), 8'(i % 2));
    end

    // Random traffic
    car = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19) == 0) car = !car;
      step(($urandom_range(999) == 0), ($urandom_range(2) == 0), car, ($urandom_range(39) == 0));
    end

    // Reset during side green with a coincident tick
    run_until(P_SG, 1, "side3");
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    chk_out("rst_mid_side", 6'b010100, 4'd6, 4'd0, 2'b10);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk_out("after_rst", 6'b010100, 4'd5, 4'd9, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
